// File: rtl/keypad_event_encoder.sv
// Keypad front end: synchronises and debounces note and control buttons, encodes
// the held note keys to a keycode and emits press/release and control-edge pulses.
module keypad_event_encoder #(
    parameter int NUM_KEYS        = 13,
    parameter int NUM_CTRL        = 2,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_KEYS+NUM_CTRL-1:0] pb,
    input  logic                         prio_mode,
    output logic [CODE_W-1:0]            keycode,
    output logic                         key_valid,
    output logic                         press_pulse,
    output logic [CODE_W-1:0]            press_code,
    output logic                         release_pulse,
    output logic [NUM_CTRL-1:0]          ctrl_level,
    output logic [NUM_CTRL-1:0]          ctrl_rise
);

    localparam int                NB       = NUM_KEYS + NUM_CTRL;
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CODE_W-1:0] NO_KEY   = '1;

    logic [NB-1:0]          sync_a;
    logic [NB-1:0]          sync_b;
    logic [NB-1:0]          st;
    logic [NB-1:0]          st_d;
    logic [CNT_W-1:0]       cnt [NB];
    logic [CODE_W-1:0]      last_key;
    logic [NB-1:0]          rise_bits;
    logic [NB-1:0]          fall_bits;
    logic [2**CODE_W-1:0]   held_pad;
    logic [CODE_W-1:0]      lowest_held;

    // Lowest set index among the note keys, or all-ones when none is set.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] code;
        code = NO_KEY;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            // NOTE: non-blocking so sync_b takes sync_a's pre-edge value, forming two real flops.
            sync_a <= pb;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= '0;
            st_d <= '0;
            // NOTE: the counter array is reset explicitly so a reset mid-debounce discards partial counts.
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            st_d <= st;
            for (int i = 0; i < NB; i++) begin
                if (sync_b[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    st[i]  <= sync_b[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise_bits     = st & ~st_d;
    assign fall_bits     = ~st & st_d;
    assign press_pulse   = |rise_bits[NUM_KEYS-1:0];
    assign press_code    = lowest_index(rise_bits[NUM_KEYS-1:0]);
    assign release_pulse = |fall_bits[NUM_KEYS-1:0];
    assign ctrl_rise     = rise_bits[NB-1:NUM_KEYS];
    assign ctrl_level    = st[NB-1:NUM_KEYS];
    assign key_valid     = |st[NUM_KEYS-1:0];

    // last_key survives releases so most-recent priority can resume once it is held again.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_key <= '0;
        end else if (press_pulse) begin
            last_key <= press_code;
        end
    end

    always_comb begin
        // NOTE: every output of this block is assigned up front, so no path can infer a latch.
        held_pad                 = '0;
        held_pad[NUM_KEYS-1:0]   = st[NUM_KEYS-1:0];
        lowest_held              = lowest_index(st[NUM_KEYS-1:0]);
        keycode                  = lowest_held;
        if (prio_mode && held_pad[last_key]) keycode = last_key;
    end

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Scoreboard bench for keypad_event_encoder: stimulus queues expected pulse events,
// a negedge monitor pops and compares them whenever the DUT pulses.
module tb_keypad_event_encoder;

    localparam int NUM_KEYS = 13;
    localparam int NUM_CTRL = 2;
    localparam int CODE_W   = 4;
    localparam int DB       = 4;
    localparam int LAT      = DB + 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_KEYS+NUM_CTRL-1:0] pb;
    logic                         prio_mode;
    logic [CODE_W-1:0]            keycode;
    logic                         key_valid;
    logic                         press_pulse;
    logic [CODE_W-1:0]            press_code;
    logic                         release_pulse;
    logic [NUM_CTRL-1:0]          ctrl_level;
    logic [NUM_CTRL-1:0]          ctrl_rise;

    keypad_event_encoder #(
        .NUM_KEYS(NUM_KEYS), .NUM_CTRL(NUM_CTRL), .CODE_W(CODE_W), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .rst(rst), .pb(pb), .prio_mode(prio_mode),
        .keycode(keycode), .key_valid(key_valid),
        .press_pulse(press_pulse), .press_code(press_code),
        .release_pulse(release_pulse),
        .ctrl_level(ctrl_level), .ctrl_rise(ctrl_rise)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_PRESS, EV_RELEASE, EV_CTRL0, EV_CTRL1} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        logic [CODE_W-1:0] code;
        int                at;
    } ev_t;

    ev_t exp_q[$];
    int  total  = 0;
    int  bad    = 0;
    int  cyc    = 0;
    bit  mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right after driving pb: the transition is accepted LAT edges later.
    task automatic expect_ev(input ev_kind_t k, input logic [CODE_W-1:0] code);
        ev_t e;
        e.kind = k;
        e.code = code;
        e.at   = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic take(input ev_kind_t k, input logic [CODE_W-1:0] code);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d code %0h expected none (cycle %0d)", k, code, cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            if (e.kind == EV_PRESS) check("press_code", 32'(code), 32'(e.code));
            check("event_cycle", cyc, e.at);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (!press_pulse) check("press_code_idle", 32'(press_code), 32'hF);
            if (press_pulse)   take(EV_PRESS, press_code);
            if (release_pulse) take(EV_RELEASE, 4'hF);
            if (ctrl_rise[0])  take(EV_CTRL0, 4'hF);
            if (ctrl_rise[1])  take(EV_CTRL1, 4'hF);
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_event: got nothing expected kind %0d at cycle %0d", exp_q[0].kind, exp_q[0].at);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_keycode"}, 32'(keycode), 32'hF);
        check({tag, "_key_valid"}, 32'(key_valid), 32'h0);
        check({tag, "_press_code"}, 32'(press_code), 32'hF);
        check({tag, "_pulses"}, {29'h0, press_pulse, release_pulse, |ctrl_rise}, 32'h0);
        check({tag, "_ctrl_level"}, 32'(ctrl_level), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        pb        = '0;
        prio_mode = 1'b0;
        step(1);
        mon_on = 1'b1;
        check_idle("reset");
        step(2);
        rst = 1'b0;
        step(1);
        check_idle("post_reset");

        // Single key, lowest mode.
        pb[4] = 1'b1; expect_ev(EV_PRESS, 4'h4);
        step(LAT - 1);
        check("k4_not_yet", 32'(key_valid), 32'h0);
        step(1);
        check("k4_keycode", 32'(keycode), 32'h4);
        check("k4_valid", 32'(key_valid), 32'h1);
        step(4);
        pb[4] = 1'b0; expect_ev(EV_RELEASE, 4'hF);
        step(LAT);
        check("k4_rel_keycode", 32'(keycode), 32'hF);
        check("k4_rel_valid", 32'(key_valid), 32'h0);
        step(3);

        // Glitch of DB-1 cycles is rejected; DB cycles is accepted.
        pb[2] = 1'b1;
        step(DB - 1);
        pb[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("glitch_valid", 32'(key_valid), 32'h0);
        end
        pb[2] = 1'b1; expect_ev(EV_PRESS, 4'h2);
        step(DB);
        pb[2] = 1'b0; expect_ev(EV_RELEASE, 4'hF);
        step(2);
        check("db_keycode", 32'(keycode), 32'h2);
        step(10);
        check("db_released", 32'(key_valid), 32'h0);

        // Priority modes.
        pb[7] = 1'b1; expect_ev(EV_PRESS, 4'h7);
        step(LAT + 4);
        check("p7_keycode", 32'(keycode), 32'h7);
        pb[3] = 1'b1; expect_ev(EV_PRESS, 4'h3);
        step(LAT + 2);
        check("mode0_lowest", 32'(keycode), 32'h3);
        prio_mode = 1'b1;
        #1;
        check("mode1_latest", 32'(keycode), 32'h3);
        step(1);
        pb[3] = 1'b0; expect_ev(EV_RELEASE, 4'hF);
        step(LAT);
        check("mode1_fallback", 32'(keycode), 32'h7);
        step(2);
        pb[9] = 1'b1; expect_ev(EV_PRESS, 4'h9);
        step(LAT + 1);
        check("mode1_press9", 32'(keycode), 32'h9);
        prio_mode = 1'b0;
        #1;
        check("mode_toggle", 32'(keycode), 32'h7);
        step(1);
        pb[7] = 1'b0; pb[9] = 1'b0; expect_ev(EV_RELEASE, 4'hF);
        step(LAT + 2);
        check("prio_all_rel", 32'(key_valid), 32'h0);

        // Simultaneous presses, then a press and a release in the same cycle.
        prio_mode = 1'b1;
        pb[5] = 1'b1; pb[1] = 1'b1; expect_ev(EV_PRESS, 4'h1);
        step(LAT + 1);
        check("sim_keycode", 32'(keycode), 32'h1);
        pb[1] = 1'b0; pb[8] = 1'b1;
        expect_ev(EV_PRESS, 4'h8);
        expect_ev(EV_RELEASE, 4'hF);
        step(LAT + 1);
        check("swap_mode1", 32'(keycode), 32'h8);
        prio_mode = 1'b0;
        #1;
        check("swap_mode0", 32'(keycode), 32'h5);
        step(1);
        pb[5] = 1'b0; pb[8] = 1'b0; expect_ev(EV_RELEASE, 4'hF);
        step(LAT + 2);

        // Control edges three cycles apart, then held without re-pulsing.
        pb[13] = 1'b1; expect_ev(EV_CTRL0, 4'hF);
        step(3);
        pb[14] = 1'b1; expect_ev(EV_CTRL1, 4'hF);
        step(LAT);
        check("ctrl_level_on", 32'(ctrl_level), 32'h3);
        check("ctrl_no_key", 32'(key_valid), 32'h0);
        step(100);
        check("ctrl_level_held", 32'(ctrl_level), 32'h3);
        pb[13] = 1'b0; pb[14] = 1'b0;
        step(LAT + 2);
        check("ctrl_level_off", 32'(ctrl_level), 32'h0);

        // Reset while a key is held: re-accepted with a fresh press.
        pb[6] = 1'b1; expect_ev(EV_PRESS, 4'h6);
        step(LAT + 2);
        check("k6_keycode", 32'(keycode), 32'h6);
        rst = 1'b1;
        step(1);
        check_idle("mid_reset");
        step(1);
        rst = 1'b0; expect_ev(EV_PRESS, 4'h6);
        step(LAT - 1);
        check("k6_not_yet", 32'(key_valid), 32'h0);
        step(1);
        check("k6_reaccept", 32'(keycode), 32'h6);
        check("k6_valid", 32'(key_valid), 32'h1);
        step(2);
        pb[6] = 1'b0; expect_ev(EV_RELEASE, 4'hF);
        step(LAT + 3);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
